// File: rtl/prog_load_sequencer.sv
// prog_load_sequencer
//   Program-load controller. Accepts a 32-bit word stream (valid/ready),
//   parses a two-word header (imem word count n_i, dmem word count n_d),
//   then emits 128-bit imem line writes followed by 32-bit dmem word writes
//   on the shared load port.
// Ports:
//   clk        rising-edge clock
//   reset_x    asynchronous active-low reset
//   start      begin a load (honoured only in IDLE, DONE or ERR)
//   in_valid   stream word valid
//   in_data    stream word
//   in_ready   word accepted this cycle when in_valid is also high
//   loading    load-port mux select; holds the core in reset
//   load_addr  byte address (line*16 for imem, word*4 for dmem)
//   load_data  imem line on [127:0], dmem word on [127:96]
//   we_128     imem line write strobe (one cycle)
//   we_32      dmem word write strobe (one cycle)
//   done       sticky load-complete flag
//   err        sticky header-error flag
module prog_load_sequencer #(
    parameter int IMEM_LINES = 512,
    parameter int DMEM_WORDS = 4096
) (
    input  logic         clk,
    input  logic         reset_x,
    input  logic         start,
    input  logic         in_valid,
    input  logic [31:0]  in_data,
    output logic         in_ready,
    output logic         loading,
    output logic [31:0]  load_addr,
    output logic [127:0] load_data,
    output logic         we_128,
    output logic         we_32,
    output logic         done,
    output logic         err
);

    localparam int LW = $clog2(IMEM_LINES) + 1;
    localparam int IW = $clog2(DMEM_WORDS) + 1;
    localparam logic [31:0] MAX_I = 32'(4 * IMEM_LINES);
    localparam logic [31:0] MAX_D = 32'(DMEM_WORDS);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR_I = 3'd1,
        ST_HDR_D = 3'd2,
        ST_IMEM  = 3'd3,
        ST_DMEM  = 3'd4,
        ST_FLUSH = 3'd5,
        ST_DONE  = 3'd6,
        ST_ERR   = 3'd7
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic            in_ready_r;
    logic            loading_r;
    logic            done_r;
    logic            err_r;
    logic [31:0]     load_addr_r;
    logic [127:0]    load_data_r;
    logic            we_128_r;
    logic            we_32_r;
    logic [LW-1:0]   line_cnt_r;
    logic [LW-1:0]   n_lines_r;
    logic [IW-1:0]   idx_r;
    logic [IW-1:0]   n_d_r;
    logic [1:0]      pack_cnt_r;
    logic [95:0]     pack_buf_r;

    logic            beat_s;
    logic            start_s;
    logic            imem_last_s;
    logic            dmem_last_s;
    logic            hdr_i_bad_s;
    logic            hdr_d_bad_s;

    assign in_ready  = in_ready_r;
    assign loading   = loading_r;
    assign done      = done_r;
    assign err       = err_r;
    assign load_addr = load_addr_r;
    assign load_data = load_data_r;
    assign we_128    = we_128_r;
    assign we_32     = we_32_r;

    assign beat_s      = in_valid && in_ready_r;
    assign start_s     = start && ((state_r == ST_IDLE) || (state_r == ST_DONE) || (state_r == ST_ERR));
    // Header bounds guarantee these counters never wrap inside a legal load.
    assign imem_last_s = (pack_cnt_r == 2'd3) && ((line_cnt_r + LW'(1)) == n_lines_r);
    assign dmem_last_s = ((idx_r + IW'(1)) == n_d_r);
    assign hdr_i_bad_s = (in_data[1:0] != 2'b00) || (in_data > MAX_I);
    assign hdr_d_bad_s = (in_data > MAX_D);

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) state_nxt_s = ST_HDR_I;
                else       state_nxt_s = state_r;
            end
            ST_HDR_I: begin
                if (beat_s) state_nxt_s = hdr_i_bad_s ? ST_ERR : ST_HDR_D;
                else        state_nxt_s = state_r;
            end
            ST_HDR_D: begin
                if (!beat_s)                  state_nxt_s = state_r;
                else if (hdr_d_bad_s)         state_nxt_s = ST_ERR;
                else if (n_lines_r != '0)     state_nxt_s = ST_IMEM;
                else if (in_data != 32'd0)    state_nxt_s = ST_DMEM;
                else                          state_nxt_s = ST_FLUSH;
            end
            ST_IMEM: begin
                if (beat_s && imem_last_s) state_nxt_s = (n_d_r != '0) ? ST_DMEM : ST_FLUSH;
                else                       state_nxt_s = state_r;
            end
            ST_DMEM: begin
                if (beat_s && dmem_last_s) state_nxt_s = ST_FLUSH;
                else                       state_nxt_s = state_r;
            end
            ST_FLUSH: state_nxt_s = ST_DONE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // State register plus status outputs registered from the next state.
    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            state_r    <= ST_IDLE;
            in_ready_r <= 1'b0;
            loading_r  <= 1'b1;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            in_ready_r <= (state_nxt_s == ST_HDR_I) || (state_nxt_s == ST_HDR_D) ||
                          (state_nxt_s == ST_IMEM)  || (state_nxt_s == ST_DMEM);
            loading_r  <= (state_nxt_s != ST_DONE);
            done_r     <= (state_nxt_s == ST_DONE);
            err_r      <= (state_nxt_s == ST_ERR);
        end
    end

    // Header latching, line packing, counters and registered write strobes.
    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            load_addr_r <= 32'd0;
            load_data_r <= 128'd0;
            we_128_r    <= 1'b0;
            we_32_r     <= 1'b0;
            line_cnt_r  <= '0;
            n_lines_r   <= '0;
            idx_r       <= '0;
            n_d_r       <= '0;
            pack_cnt_r  <= 2'd0;
            pack_buf_r  <= 96'd0;
        end else begin
            we_128_r <= 1'b0;
            we_32_r  <= 1'b0;
            if (start_s) begin
                line_cnt_r <= '0;
                n_lines_r  <= '0;
                idx_r      <= '0;
                n_d_r      <= '0;
                pack_cnt_r <= 2'd0;
            end else if (beat_s) begin
                case (state_r)
                    ST_HDR_I: n_lines_r <= in_data[LW+1:2];
                    ST_HDR_D: n_d_r     <= in_data[IW-1:0];
                    ST_IMEM: begin
                        if (pack_cnt_r == 2'd3) begin
                            // Oldest word lands in [127:96], this beat in [31:0].
                            load_data_r <= {pack_buf_r, in_data};
                            load_addr_r <= 32'({line_cnt_r, 4'b0000});
                            we_128_r    <= 1'b1;
                            line_cnt_r  <= line_cnt_r + LW'(1);
                            pack_cnt_r  <= 2'd0;
                        end else begin
                            pack_buf_r  <= {pack_buf_r[63:0], in_data};
                            pack_cnt_r  <= pack_cnt_r + 2'd1;
                        end
                    end
                    ST_DMEM: begin
                        load_data_r <= {in_data, 96'd0};
                        load_addr_r <= 32'({idx_r, 2'b00});
                        we_32_r     <= 1'b1;
                        idx_r       <= idx_r + IW'(1);
                    end
                    default: begin
                        load_addr_r <= load_addr_r;
                    end
                endcase
            end else begin
                pack_cnt_r <= pack_cnt_r;
            end
        end
    end

endmodule

// File: tb/tb_prog_load_sequencer.sv
// Testbench for prog_load_sequencer: directed scenarios plus randomized loads
// checked against a queue-based model of the expected write sequence.
module tb_prog_load_sequencer;

    localparam int IMEM_LINES = 8;
    localparam int DMEM_WORDS = 16;

    logic         clk = 1'b0;
    logic         reset_x;
    logic         start;
    logic         in_valid;
    logic [31:0]  in_data;
    logic         in_ready;
    logic         loading;
    logic [31:0]  load_addr;
    logic [127:0] load_data;
    logic         we_128;
    logic         we_32;
    logic         done;
    logic         err;

    typedef struct {
        bit           w128;
        logic [31:0]  addr;
        logic [127:0] data;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] stream_q[$];
    int          n_checks = 0;
    int          n_errors = 0;

    prog_load_sequencer #(.IMEM_LINES(IMEM_LINES), .DMEM_WORDS(DMEM_WORDS)) dut (
        .clk(clk), .reset_x(reset_x), .start(start), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready), .loading(loading),
        .load_addr(load_addr), .load_data(load_data), .we_128(we_128),
        .we_32(we_32), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected write list from the header and payload in stream_q.
    task automatic build_exp();
        int ni;
        int nd;
        wr_t w;
        ni = int'(stream_q[0]);
        nd = int'(stream_q[1]);
        exp_q.delete();
        for (int l = 0; l < ni / 4; l++) begin
            w.w128 = 1'b1;
            w.addr = 32'(l * 16);
            w.data = {stream_q[2 + 4*l], stream_q[3 + 4*l], stream_q[4 + 4*l], stream_q[5 + 4*l]};
            exp_q.push_back(w);
        end
        for (int d = 0; d < nd; d++) begin
            w.w128 = 1'b0;
            w.addr = 32'(d * 4);
            w.data = {stream_q[2 + ni + d], 96'd0};
            exp_q.push_back(w);
        end
    endtask

    task automatic prep(input int ni, input int nd);
        stream_q.delete();
        stream_q.push_back(32'(ni));
        stream_q.push_back(32'(nd));
        for (int k = 0; k < ni + nd; k++) stream_q.push_back($urandom);
    endtask

    task automatic do_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check_eq("start_in_ready", in_ready, 1'b1);
        check_eq("start_loading", loading, 1'b1);
        check_eq("start_done_clr", done, 1'b0);
        check_eq("start_err_clr", err, 1'b0);
    endtask

    // mode 0: always valid, 1: valid every third cycle, 2: random valid.
    task automatic send(input int mode, input int start_at);
        int  i = 0;
        int  cyc = 0;
        bit  beat;
        while (i < stream_q.size() && cyc < 2000) begin
            case (mode)
                0:       in_valid = 1'b1;
                1:       in_valid = (cyc % 3 == 0);
                default: in_valid = 1'($urandom_range(0, 1));
            endcase
            in_data = stream_q[i];
            start   = (i == start_at);
            beat    = in_valid && in_ready;
            @(posedge clk); #1;
            cyc++;
            if (beat) i++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        in_data  = $urandom;
        check_eq("stream_consumed", 128'(i), 128'(stream_q.size()));
    endtask

    // Called right after the last beat: FLUSH now, DONE one cycle later.
    task automatic finish_check();
        check_eq("flush_in_ready", in_ready, 1'b0);
        check_eq("flush_loading", loading, 1'b1);
        check_eq("flush_done", done, 1'b0);
        @(posedge clk); #1;
        check_eq("done_flag", done, 1'b1);
        check_eq("done_loading", loading, 1'b0);
        check_eq("done_err", err, 1'b0);
        check_eq("writes_drained", 128'(exp_q.size()), 128'd0);
    endtask

    task automatic run_load(input int mode, input int start_at);
        build_exp();
        do_start();
        send(mode, start_at);
        finish_check();
    endtask

    task automatic run_bad(input int ni, input int nd, input bit two_words);
        exp_q.delete();
        stream_q.delete();
        stream_q.push_back(32'(ni));
        if (two_words) stream_q.push_back(32'(nd));
        do_start();
        send(0, -1);
        check_eq("bad_err", err, 1'b1);
        check_eq("bad_loading", loading, 1'b1);
        check_eq("bad_done", done, 1'b0);
        // Words offered in ERR must not be taken.
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_data = $urandom;
            @(posedge clk); #1;
            check_eq("err_in_ready", in_ready, 1'b0);
        end
        in_valid = 1'b0;
    endtask

    task automatic load_fixed();
        stream_q.delete();
        stream_q = '{32'd8, 32'd2, 32'h11, 32'h22, 32'h33, 32'h44,
                     32'h55, 32'h66, 32'h77, 32'h88, 32'hA, 32'hB};
    endtask

    // Strobe monitor: every write must match the next expected one.
    always @(negedge clk) begin
        if (reset_x && (we_128 || we_32)) begin
            check_eq("strobe_exclusive", 128'(we_128 & we_32), 128'd0);
            check_eq("strobe_loading", loading, 1'b1);
            check_eq("strobe_expected", 128'(exp_q.size() != 0), 128'd1);
            if (exp_q.size() != 0) begin
                check_eq("strobe_kind", we_128, exp_q[0].w128);
                check_eq("strobe_addr", load_addr, exp_q[0].addr);
                check_eq("strobe_data", load_data, exp_q[0].data);
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        reset_x  = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 32'd0;
        #12;
        check_eq("rst_loading", loading, 1'b1);
        check_eq("rst_in_ready", in_ready, 1'b0);
        check_eq("rst_we_128", we_128, 1'b0);
        check_eq("rst_we_32", we_32, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_err", err, 1'b0);
        check_eq("rst_addr", load_addr, 32'd0);
        check_eq("rst_data", load_data, 128'd0);
        reset_x = 1'b1;

        // Idle: stream words are not accepted before start.
        in_valid = 1'b1;
        @(posedge clk); #1;
        check_eq("idle_in_ready", in_ready, 1'b0);
        in_valid = 1'b0;

        // Normal load, back to back, then throttled.
        load_fixed();
        run_load(0, -1);
        load_fixed();
        run_load(1, -1);

        // Empty load.
        prep(0, 0);
        run_load(0, -1);

        // Header errors, each followed by a legal load.
        run_bad(6, 0, 1'b0);
        prep(4, 3);
        run_load(0, -1);
        run_bad(4, DMEM_WORDS + 1, 1'b1);
        run_bad(4 * IMEM_LINES + 4, 0, 1'b0);
        prep(4 * IMEM_LINES, DMEM_WORDS);
        run_load(0, -1);

        // Start pulsed in DMEM is ignored.
        load_fixed();
        run_load(0, 10);

        // Reset after the second imem beat.
        load_fixed();
        exp_q.delete();
        void'(stream_q.pop_back());
        for (int k = 0; k < 7; k++) void'(stream_q.pop_back());
        do_start();
        send(0, -1);
        reset_x = 1'b0;
        #1;
        check_eq("mid_rst_loading", loading, 1'b1);
        check_eq("mid_rst_we_128", we_128, 1'b0);
        check_eq("mid_rst_we_32", we_32, 1'b0);
        check_eq("mid_rst_in_ready", in_ready, 1'b0);
        #5;
        reset_x = 1'b1;
        prep(8, 1);
        run_load(0, -1);

        // Randomized loads.
        for (int r = 0; r < 15; r++) begin
            prep(4 * $urandom_range(0, IMEM_LINES), $urandom_range(0, DMEM_WORDS));
            run_load(2, -1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
